// File: rtl/hazard_scoreboard_pkg.sv
// Shared processor definitions: register index width, scoreboard FSM states, issue bundle.
// No logic; types and constants only.
// Backpressure: n/a.
package hazard_scoreboard_pkg;

    localparam int REGW = 4;

    typedef logic [REGW-1:0] reg_idx_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } sb_state_e;

    typedef struct packed {
        logic     vld;
        reg_idx_t rd;
        reg_idx_t rs;
        logic     immf;
        logic     rdrd;
        logic     wr;
    } issue_t;

endpackage

// File: rtl/sb_counter.sv
// Per-register pending-write counter: saturating inc/dec with zero/full/last flags.
// Latency: count updates on the next rising edge; flags are combinational from the count.
// Backpressure: inc at full and dec at zero are dropped; simultaneous inc+dec cancel.
module sb_counter #(
    parameter int CNTW = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    output logic zero,
    output logic full,
    output logic last,
    output logic uflow
);

    logic [CNTW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (inc && !dec && !full) begin
            cnt_q <= cnt_q + CNTW'(1);
        end else if (dec && !inc && !zero) begin
            cnt_q <= cnt_q - CNTW'(1);
        end
    end

    assign zero  = (cnt_q == '0);
    assign full  = (cnt_q == '1);
    assign last  = (cnt_q == CNTW'(1));
    assign uflow = dec & zero;

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: tracks pending writes per register, stalls RAW/WAW-overflow issue.
// Latency: stall_o/issue_ok_o combinational; counters and FSM update on the next rising edge.
// Backpressure: stall_o holds ID on hazard, stall_i, or while draining after a flush.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NREG = 16,
    parameter int CNTW = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_v_i,
    input  logic [REGW-1:0] issue_rd_i,
    input  logic [REGW-1:0] issue_rs_i,
    input  logic            issue_immf_i,
    input  logic            issue_rdrd_i,
    input  logic            issue_wr_i,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic            wb_i,
    input  logic [REGW-1:0] wb_r_i,
    output logic            stall_o,
    output logic            issue_ok_o,
    output logic [NREG-1:0] busy_o,
    output logic [1:0]      state_o,
    output logic            err_o
);

    issue_t          iss;
    sb_state_e       state_q, state_d;
    logic [NREG-1:0] zero_vec, full_vec, last_vec, uflow_vec, inc_vec, dec_vec;
    logic            hazard, drain_done, err_q;

    assign iss = '{vld: issue_v_i, rd: issue_rd_i, rs: issue_rs_i,
                   immf: issue_immf_i, rdrd: issue_rdrd_i, wr: issue_wr_i};

    for (genvar i = 0; i < NREG; i++) begin : g_cnt
        assign inc_vec[i] = issue_ok_o & iss.wr & (iss.rd == REGW'(i));
        assign dec_vec[i] = wb_i & (wb_r_i == REGW'(i));

        sb_counter #(.CNTW(CNTW)) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .inc   (inc_vec[i]),
            .dec   (dec_vec[i]),
            .zero  (zero_vec[i]),
            .full  (full_vec[i]),
            .last  (last_vec[i]),
            .uflow (uflow_vec[i])
        );
    end

    // No bypass: a write-back retiring this cycle still counts as pending.
    assign hazard = iss.vld & ((~iss.immf & ~zero_vec[iss.rs]) |
                               (iss.rdrd  & ~zero_vec[iss.rd]) |
                               (iss.wr    &  full_vec[iss.rd]));

    // Drain ends on the edge that retires the last outstanding write.
    assign drain_done = &(zero_vec | (last_vec & dec_vec));

    always_comb begin
        stall_o = 1'b1;
        case (state_q)
            RUN:     stall_o = stall_i | hazard;
            HOLD:    stall_o = stall_i | hazard;
            DRAIN:   stall_o = 1'b1;
            default: stall_o = 1'b1;
        endcase
    end

    assign issue_ok_o = issue_v_i & ~stall_o & rst;

    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = DRAIN;
        end else begin
            case (state_q)
                RUN:     if (hazard)     state_d = HOLD;
                HOLD:    if (!hazard)    state_d = RUN;
                DRAIN:   if (drain_done) state_d = RUN;
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (|uflow_vec) err_q <= 1'b1;
        end
    end

    assign busy_o  = ~zero_vec;
    assign state_o = state_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard: vector table plus multi-cycle sequences.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_v_i, issue_immf_i, issue_rdrd_i, issue_wr_i;
    logic [3:0]  issue_rd_i, issue_rs_i, wb_r_i;
    logic        stall_i, flush_i, wb_i;
    logic        stall_o, issue_ok_o, err_o;
    logic [15:0] busy_o;
    logic [1:0]  state_o;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.NREG(16), .CNTW(2)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .issue_v_i    (issue_v_i),
        .issue_rd_i   (issue_rd_i),
        .issue_rs_i   (issue_rs_i),
        .issue_immf_i (issue_immf_i),
        .issue_rdrd_i (issue_rdrd_i),
        .issue_wr_i   (issue_wr_i),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .wb_i         (wb_i),
        .wb_r_i       (wb_r_i),
        .stall_o      (stall_o),
        .issue_ok_o   (issue_ok_o),
        .busy_o       (busy_o),
        .state_o      (state_o),
        .err_o        (err_o)
    );

    typedef struct {
        logic        iv;
        logic [3:0]  rd;
        logic [3:0]  rs;
        logic        immf;
        logic        rdrd;
        logic        wr;
        logic        stl;
        logic        fl;
        logic        wb;
        logic [3:0]  wbr;
        logic        e_stall;
        logic        e_ok;
        logic [15:0] e_busy;
        logic [1:0]  e_state;
        logic        e_err;
    } vec_t;

    vec_t tbl[20];

    function automatic vec_t mk(input logic iv, input logic [3:0] rd, input logic [3:0] rs,
                                input logic immf, input logic rdrd, input logic wr,
                                input logic stl, input logic fl, input logic wb,
                                input logic [3:0] wbr, input logic es, input logic eo,
                                input logic [15:0] eb, input logic [1:0] est, input logic ee);
        vec_t v;
        v.iv = iv; v.rd = rd; v.rs = rs; v.immf = immf; v.rdrd = rdrd; v.wr = wr;
        v.stl = stl; v.fl = fl; v.wb = wb; v.wbr = wbr;
        v.e_stall = es; v.e_ok = eo; v.e_busy = eb; v.e_state = est; v.e_err = ee;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [3:0] rd, input logic [3:0] rs,
                         input logic immf, input logic rdrd, input logic wr, input logic stl,
                         input logic fl, input logic wb, input logic [3:0] wbr);
        issue_v_i = iv; issue_rd_i = rd; issue_rs_i = rs; issue_immf_i = immf;
        issue_rdrd_i = rdrd; issue_wr_i = wr; stall_i = stl; flush_i = fl;
        wb_i = wb; wb_r_i = wbr;
    endtask

    task automatic expect_all(input string tag, input logic es, input logic eo,
                              input logic [15:0] eb, input logic [1:0] est, input logic ee);
        chk({tag, ".stall"}, 16'(stall_o), 16'(es));
        chk({tag, ".ok"}, 16'(issue_ok_o), 16'(eo));
        chk({tag, ".busy"}, busy_o, eb);
        chk({tag, ".state"}, 16'(state_o), 16'(est));
        chk({tag, ".err"}, 16'(err_o), 16'(ee));
    endtask

    // One cycle: drive after the falling edge, check 1ns later, well before the rising edge.
    task automatic cyc(input string tag, input logic iv, input logic [3:0] rd, input logic [3:0] rs,
                       input logic immf, input logic rdrd, input logic wr, input logic fl,
                       input logic wb, input logic [3:0] wbr, input logic es, input logic eo,
                       input logic [15:0] eb, input logic [1:0] est, input logic ee);
        @(negedge clk);
        drive(iv, rd, rs, immf, rdrd, wr, 1'b0, fl, wb, wbr);
        #1;
        expect_all(tag, es, eo, eb, est, ee);
    endtask

    initial begin
        //              iv rd rs immf rdrd wr stl fl wb wbr | stall ok busy     st err
        tbl[0]  = mk(1, 3, 0, 1, 0, 1, 0, 0, 0, 0,  0, 1, 16'h0000, 0, 0);
        tbl[1]  = mk(1, 6, 3, 0, 0, 1, 0, 0, 0, 0,  1, 0, 16'h0008, 0, 0);
        tbl[2]  = mk(1, 6, 3, 0, 0, 1, 0, 0, 0, 0,  1, 0, 16'h0008, 1, 0);
        tbl[3]  = mk(1, 6, 3, 0, 0, 1, 0, 0, 1, 3,  1, 0, 16'h0008, 1, 0);
        tbl[4]  = mk(1, 6, 3, 0, 0, 1, 0, 0, 0, 0,  0, 1, 16'h0000, 1, 0);
        tbl[5]  = mk(1, 3, 0, 1, 0, 1, 0, 0, 0, 0,  0, 1, 16'h0040, 0, 0);
        tbl[6]  = mk(1, 4, 3, 1, 0, 1, 0, 0, 0, 0,  0, 1, 16'h0048, 0, 0);
        tbl[7]  = mk(1, 7, 0, 1, 0, 1, 0, 0, 1, 6,  0, 1, 16'h0058, 0, 0);
        tbl[8]  = mk(1, 7, 0, 1, 0, 1, 0, 0, 1, 7,  0, 1, 16'h0098, 0, 0);
        tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 7,  0, 0, 16'h0098, 0, 0);
        tbl[10] = mk(1, 8, 0, 1, 0, 1, 1, 0, 0, 0,  1, 0, 16'h0018, 0, 0);
        tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 9,  0, 0, 16'h0018, 0, 0);
        tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 3,  0, 0, 16'h0018, 0, 1);
        tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 4,  0, 0, 16'h0010, 0, 1);
        tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 16'h0000, 0, 1);
        tbl[15] = mk(1, 2, 0, 1, 0, 1, 0, 0, 0, 0,  0, 1, 16'h0000, 0, 1);
        tbl[16] = mk(1, 2, 0, 1, 1, 0, 0, 0, 0, 0,  1, 0, 16'h0004, 0, 1);
        tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 16'h0004, 1, 1);
        tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2,  0, 0, 16'h0004, 0, 1);
        tbl[19] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 16'h0000, 0, 1);

        // Reset held with a valid write presented: nothing may be accepted.
        rst = 1'b0;
        drive(1, 3, 0, 1, 0, 1, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        chk("reset.ok", 16'(issue_ok_o), 16'd0);
        chk("reset.busy", busy_o, 16'h0000);
        chk("reset.state", 16'(state_o), 16'd0);
        chk("reset.err", 16'(err_o), 16'd0);
        @(negedge clk);
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // RAW hold, immediate form, same-cycle inc/dec, stall_i, underflow, rd-read hazard.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive(tbl[i].iv, tbl[i].rd, tbl[i].rs, tbl[i].immf, tbl[i].rdrd, tbl[i].wr,
                  tbl[i].stl, tbl[i].fl, tbl[i].wb, tbl[i].wbr);
            #1;
            expect_all($sformatf("vec%0d", i), tbl[i].e_stall, tbl[i].e_ok,
                       tbl[i].e_busy, tbl[i].e_state, tbl[i].e_err);
        end

        // Saturation on r5: three writes fill it, the fourth waits for one write-back.
        cyc("sat1", 1, 5, 0, 1, 0, 1, 0, 0, 0,  0, 1, 16'h0000, 0, 1);
        cyc("sat2", 1, 5, 0, 1, 0, 1, 0, 0, 0,  0, 1, 16'h0020, 0, 1);
        cyc("sat3", 1, 5, 0, 1, 0, 1, 0, 0, 0,  0, 1, 16'h0020, 0, 1);
        cyc("sat4", 1, 5, 0, 1, 0, 1, 0, 0, 0,  1, 0, 16'h0020, 0, 1);
        cyc("sat5", 1, 5, 0, 1, 0, 1, 0, 0, 0,  1, 0, 16'h0020, 1, 1);
        cyc("sat6", 1, 5, 0, 1, 0, 1, 0, 1, 5,  1, 0, 16'h0020, 1, 1);
        cyc("sat7", 1, 5, 0, 1, 0, 1, 0, 0, 0,  0, 1, 16'h0020, 1, 1);
        cyc("sat8", 1, 5, 0, 1, 0, 1, 0, 0, 0,  1, 0, 16'h0020, 0, 1);
        cyc("sat9", 0, 0, 0, 0, 0, 0, 0, 1, 5,  0, 0, 16'h0020, 1, 1);
        cyc("sat10", 0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 16'h0020, 0, 1);
        cyc("sat11", 0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 16'h0020, 0, 1);
        cyc("sat12", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 1);

        // Flush with r1=1, r2=2: drain through three write-backs, issue blocked meanwhile.
        cyc("fl1", 1, 1, 0, 1, 0, 1, 0, 0, 0,   0, 1, 16'h0000, 0, 1);
        cyc("fl2", 1, 2, 0, 1, 0, 1, 0, 0, 0,   0, 1, 16'h0002, 0, 1);
        cyc("fl3", 1, 2, 0, 1, 0, 1, 0, 0, 0,   0, 1, 16'h0006, 0, 1);
        cyc("fl4", 0, 0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 16'h0006, 0, 1);
        cyc("fl5", 1, 10, 0, 1, 0, 1, 0, 1, 1,  1, 0, 16'h0006, 2, 1);
        cyc("fl6", 1, 10, 0, 1, 0, 1, 0, 1, 2,  1, 0, 16'h0004, 2, 1);
        cyc("fl7", 1, 10, 0, 1, 0, 1, 0, 1, 2,  1, 0, 16'h0004, 2, 1);
        cyc("fl8", 1, 10, 0, 1, 0, 1, 0, 0, 0,  0, 1, 16'h0000, 0, 1);

        // Flush beats a simultaneous hazard, then reset lands mid-drain.
        cyc("pri1", 1, 11, 10, 0, 0, 1, 1, 0, 0, 1, 0, 16'h0400, 0, 1);
        cyc("pri2", 1, 11, 10, 0, 0, 1, 0, 0, 0, 1, 0, 16'h0400, 2, 1);
        @(negedge clk);
        drive(1, 11, 10, 0, 0, 1, 0, 0, 0, 0);
        rst = 1'b0;
        #1;
        chk("rstd.state", 16'(state_o), 16'd0);
        chk("rstd.busy", busy_o, 16'h0000);
        chk("rstd.err", 16'(err_o), 16'd0);
        chk("rstd.ok", 16'(issue_ok_o), 16'd0);
        @(negedge clk);
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        expect_all("post_rst", 0, 0, 16'h0000, 0, 0);
        cyc("post_rst2", 1, 12, 10, 0, 0, 1, 0, 0, 0, 0, 1, 16'h0000, 0, 0);
        cyc("post_rst3", 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 16'h1000, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
